adder_result_checker: RTL

//  Consumer side of the adder datapath: samples {a,b,sum,OF} from the adder, recomputes the expected result, and scores it.

---
 rtl/adder_result_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adder_result_checker.sv
// Scores adder results ({a,b,sum,of}) against a locally recomputed reference, gated by PLL lock.
// Build option: define STOP_ON_FAIL_EN to freeze sampling (HALT) on the first mismatch until clear.
module adder_result_checker #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sum,
  input  logic              of,
  output logic              chk_valid,
  output logic              chk_pass,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_seen,
  output logic [DATA_W-1:0] err_a,
  output logic [DATA_W-1:0] err_b,
  output logic [DATA_W-1:0] err_sum,
  output logic              err_of,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1
`ifdef STOP_ON_FAIL_EN
    ,
    HALT      = 2'd2
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;

  // Stage-1 registers: captured sample plus its reference result.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_sum;
  logic              s1_of;
  logic [DATA_W-1:0] s1_exp_sum;
  logic              s1_exp_of;

  logic              accept;
  logic [DATA_W-1:0] exp_sum;
  logic              exp_of;
  logic              s1_match;
  logic              s1_fail;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, and an offer seen while in_ready is low is dropped.
  assign in_ready  = (state == RUN);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  assign exp_sum  = a + b;
  assign exp_of   = (a[DATA_W-1] == b[DATA_W-1]) & (exp_sum[DATA_W-1] != a[DATA_W-1]);
  assign s1_match = (s1_sum == s1_exp_sum) & (s1_of == s1_exp_of);
  assign s1_fail  = s1_valid & ~s1_match;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (locked) state <= RUN;
        end
        RUN: begin
          if (!locked) state <= WAIT_LOCK;
`ifdef STOP_ON_FAIL_EN
          // A counted mismatch wins over a simultaneous lock drop.
          if (s1_fail && !clear) state <= HALT;
`endif
        end
`ifdef STOP_ON_FAIL_EN
        HALT: begin
          if (clear) state <= locked ? RUN : WAIT_LOCK;
        end
`endif
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_sum     <= '0;
      s1_of      <= 1'b0;
      s1_exp_sum <= '0;
      s1_exp_of  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a       <= a;
        s1_b       <= b;
        s1_sum     <= sum;
        s1_of      <= of;
        s1_exp_sum <= exp_sum;
        s1_exp_of  <= exp_of;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
    end else begin
      chk_valid <= s1_valid;
      chk_pass  <= s1_valid & s1_match;
    end
  end

  // Scoring happens on the same edge that raises chk_valid; clear takes precedence.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_seen <= 1'b0;
      err_a    <= '0;
      err_b    <= '0;
      err_sum  <= '0;
      err_of   <= 1'b0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_seen <= 1'b0;
      err_a    <= '0;
      err_b    <= '0;
      err_sum  <= '0;
      err_of   <= 1'b0;
    end else if (s1_valid) begin
      if (s1_match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
        err_seen <= 1'b1;
        if (!err_seen) begin
          err_a   <= s1_a;
          err_b   <= s1_b;
          err_sum <= s1_sum;
          err_of  <= s1_of;
        end
      end
    end
  end

endmodule
